// File: rtl/dcache_bypass_unit_pkg.sv
// Shared types for the uncached dcache bypass responder: FSM states, size codes
// and the captured two-slot request.
package dcache_bypass_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P0_REQ  = 3'd1,
        S_P0_WAIT = 3'd2,
        S_P1_REQ  = 3'd3,
        S_P1_WAIT = 3'd4,
        S_RESP    = 3'd5
    } dbu_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Addresses are stored fully assembled so the memory side needs no muxing of tag/index.
    typedef struct packed {
        logic        p1_valid;
        logic        p0_we;
        logic [31:0] p0_addr;
        logic [1:0]  p0_size;
        logic [3:0]  p0_wstrb;
        logic [31:0] p0_wdata;
        logic        p1_we;
        logic [31:0] p1_addr;
        logic [1:0]  p1_size;
        logic [3:0]  p1_wstrb;
        logic [31:0] p1_wdata;
    } dbu_req_t;

endpackage

// File: rtl/dcache_bypass_unit.sv
// Uncached responder for the MMU->dcache p0/p1 interface; every slot becomes one
// single-beat transaction on the SRAM-like memory bus, strictly in order.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | no request held, addr_ok high
// S_P0_REQ  | p0 presented on memory bus, waiting mem_addr_ok
// S_P0_WAIT | p0 accepted by memory, waiting mem_data_ok
// S_P1_REQ  | p1 presented on memory bus, waiting mem_addr_ok
// S_P1_WAIT | p1 accepted by memory, waiting mem_data_ok
// S_RESP    | data_ok pulse, addr_ok high for back-to-back accept
module dcache_bypass_unit
    import dcache_bypass_unit_pkg::*;
#(
    parameter int TAG_W    = 20,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p0_valid,
    input  logic                p1_valid,
    input  logic [2:0]          op,
    input  logic [TAG_W-1:0]    tag,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] p0_offset,
    input  logic [OFFSET_W-1:0] p1_offset,
    input  logic [3:0]          p0_wstrb,
    input  logic [3:0]          p1_wstrb,
    input  logic [31:0]         p0_wdata,
    input  logic [31:0]         p1_wdata,
    input  logic [1:0]          p0_size,
    input  logic [1:0]          p1_size,
    input  logic                uncached,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [31:0]         p0_rdata,
    output logic [31:0]         p1_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [1:0]          mem_size,
    output logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [31:0]         mem_rdata
);

    dbu_state_t  state_q, state_d;
    dbu_req_t    req_q;
    logic [31:0] r0_q;

    logic        accept;
    logic        p1_sel;
    logic        slot_done;
    logic        act_we;
    logic [31:0] slot_data;

    // Every access bypasses; the reserved op bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{uncached, op[2:1]};

    assign addr_ok = (state_q == S_IDLE) || (state_q == S_RESP);
    assign data_ok = (state_q == S_RESP);
    assign accept  = addr_ok && p0_valid;
    assign p1_sel  = (state_q == S_P1_REQ) || (state_q == S_P1_WAIT);

    assign mem_req   = (state_q == S_P0_REQ) || (state_q == S_P1_REQ);
    assign act_we    = p1_sel ? req_q.p1_we    : req_q.p0_we;
    assign mem_we    = act_we;
    assign mem_addr  = p1_sel ? req_q.p1_addr  : req_q.p0_addr;
    assign mem_size  = p1_sel ? req_q.p1_size  : req_q.p0_size;
    assign mem_wstrb = p1_sel ? req_q.p1_wstrb : req_q.p0_wstrb;
    assign mem_wdata = p1_sel ? req_q.p1_wdata : req_q.p0_wdata;

    // A slot can finish in its REQ cycle when memory answers address and data together.
    assign slot_done = mem_data_ok &&
                       ((state_q == S_P0_WAIT) || (state_q == S_P1_WAIT) ||
                        (mem_req && mem_addr_ok));
    assign slot_data = act_we ? 32'h0 : mem_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_P0_REQ;
            S_P0_REQ:  if (mem_addr_ok)
                           state_d = !mem_data_ok    ? S_P0_WAIT :
                                     req_q.p1_valid ? S_P1_REQ  : S_RESP;
            S_P0_WAIT: if (mem_data_ok)
                           state_d = req_q.p1_valid ? S_P1_REQ : S_RESP;
            S_P1_REQ:  if (mem_addr_ok)
                           state_d = mem_data_ok ? S_RESP : S_P1_WAIT;
            S_P1_WAIT: if (mem_data_ok) state_d = S_RESP;
            S_RESP:    state_d = accept ? S_P0_REQ : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            r0_q     <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // A slot writes only when it has strobes, so p0 read + p1 write share one op.
                req_q.p1_valid <= p1_valid;
                req_q.p0_we    <= op[0] && (p0_wstrb != 4'h0);
                req_q.p0_addr  <= {tag, index, p0_offset};
                req_q.p0_size  <= p0_size;
                req_q.p0_wstrb <= p0_wstrb;
                req_q.p0_wdata <= p0_wdata;
                req_q.p1_we    <= op[0] && (p1_wstrb != 4'h0);
                req_q.p1_addr  <= {tag, index, p1_offset};
                req_q.p1_size  <= p1_size;
                req_q.p1_wstrb <= p1_wstrb;
                req_q.p1_wdata <= p1_wdata;
            end
            if (slot_done) begin
                if (p1_sel) begin
                    p0_rdata <= r0_q;
                    p1_rdata <= slot_data;
                end else if (req_q.p1_valid) begin
                    r0_q <= slot_data;
                end else begin
                    p0_rdata <= slot_data;
                    p1_rdata <= 32'h0;
                end
            end
        end
    end

endmodule
